fake_mario_otg_hpi_bridge: RTL and testbench

//  Avalon-MM slave that executes timed HPI read/write cycles on the CY7C67200 USB OTG chip.

---
 rtl/fake_mario_otg_hpi_pkg.sv | 33 +++
 rtl/fake_mario_otg_hpi_if.sv | 20 ++
 rtl/fake_mario_otg_hpi_sync.sv | 19 +
 rtl/fake_mario_otg_hpi_bridge.sv | 127 ++++++++++++
 tb/tb_fake_mario_otg_hpi_bridge.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fake_mario_otg_hpi_pkg.sv
// Shared definitions for the CY7C67200 HPI bridge: sequencer states,
// HPI register indices and default strobe timing.
package fake_mario_otg_hpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } hpi_state_e;

  localparam logic [1:0] HPI_REG_DATA    = 2'd0;
  localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_REG_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

  localparam int unsigned DEF_SETUP_CYC    = 1;
  localparam int unsigned DEF_STROBE_CYC   = 4;
  localparam int unsigned DEF_HOLD_CYC     = 1;
  localparam int unsigned DEF_RECOVERY_CYC = 2;

  function automatic int unsigned max_cyc(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/fake_mario_otg_hpi_if.sv
// Avalon-MM slave bus between the Nios II interconnect and the HPI bridge.
interface fake_mario_otg_hpi_if;
  logic [1:0]  avs_address;
  logic        avs_chipselect;
  logic        avs_read;
  logic        avs_write;
  logic [15:0] avs_writedata;
  logic [15:0] avs_readdata;
  logic        avs_waitrequest;

  modport master (
    output avs_address, avs_chipselect, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_chipselect, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/fake_mario_otg_hpi_sync.sv
// Two-flop synchroniser for a single asynchronous level, resets to 0.
module fake_mario_otg_hpi_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/fake_mario_otg_hpi_bridge.sv
// Avalon-MM slave that sequences timed HPI read/write cycles on the CY7C67200.
// Pin outputs are registered; the inout data bus is split into in/out/oe for the top level.
module fake_mario_otg_hpi_bridge
  import fake_mario_otg_hpi_pkg::*;
#(
  parameter int unsigned SETUP_CYC    = DEF_SETUP_CYC,
  parameter int unsigned STROBE_CYC   = DEF_STROBE_CYC,
  parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
  parameter int unsigned RECOVERY_CYC = DEF_RECOVERY_CYC
) (
  input  logic                clk,
  input  logic                reset_n,
  fake_mario_otg_hpi_if.slave avs,
  output logic [1:0]          otg_hpi_addr,
  output logic                otg_hpi_cs_n,
  output logic                otg_hpi_r_n,
  output logic                otg_hpi_w_n,
  input  logic [15:0]         otg_data_in,
  output logic [15:0]         otg_data_out,
  output logic                otg_data_oe,
  input  logic                otg_hpi_int,
  output logic                irq
);

  localparam int unsigned MAX_CYC = max_cyc(SETUP_CYC, STROBE_CYC, HOLD_CYC, RECOVERY_CYC);
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] SETUP_LD    = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD   = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD     = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RECOVERY_LD = CNT_W'(RECOVERY_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  hpi_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             wr_q;
  logic             dropped;
  logic [15:0]      readdata_q;
  logic             req;
  logic             done;
  logic             accept;
  logic             cnt_zero;

  assign req      = avs.avs_chipselect & (avs.avs_read | avs.avs_write);
  assign cnt_zero = (cnt == '0);
  assign done     = (state == ST_HOLD) && cnt_zero && !dropped;
  // A request held through recovery is taken on the last recovery cycle so
  // cs_n stays high for exactly RECOVERY_CYC cycles between back-to-back accesses.
  assign accept   = req && ((state == ST_IDLE) || ((state == ST_RECOVER) && cnt_zero));

  assign avs.avs_waitrequest = req & ~done;
  assign avs.avs_readdata    = readdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      wr_q         <= 1'b0;
      dropped      <= 1'b0;
      readdata_q   <= '0;
      otg_hpi_addr <= '0;
      otg_hpi_cs_n <= 1'b1;
      otg_hpi_r_n  <= 1'b1;
      otg_hpi_w_n  <= 1'b1;
      otg_data_out <= '0;
      otg_data_oe  <= 1'b0;
    end else begin
      if ((state == ST_SETUP || state == ST_STROBE || state == ST_HOLD) && !req)
        dropped <= 1'b1;

      case (state)
        ST_IDLE: ;
        ST_SETUP:
          if (cnt_zero) begin
            state       <= ST_STROBE;
            cnt         <= STROBE_LD;
            otg_hpi_r_n <= wr_q;
            otg_hpi_w_n <= !wr_q;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        ST_STROBE:
          if (cnt_zero) begin
            state       <= ST_HOLD;
            cnt         <= HOLD_LD;
            otg_hpi_r_n <= 1'b1;
            otg_hpi_w_n <= 1'b1;
            if (!wr_q) readdata_q <= otg_data_in;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        ST_HOLD:
          if (cnt_zero) begin
            state        <= ST_RECOVER;
            cnt          <= RECOVERY_LD;
            otg_hpi_cs_n <= 1'b1;
            otg_data_oe  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        ST_RECOVER:
          if (cnt_zero) state <= ST_IDLE;
          else          cnt   <= cnt - CNT_ONE;
        default: state <= ST_IDLE;
      endcase

      if (accept) begin
        state        <= ST_SETUP;
        cnt          <= SETUP_LD;
        wr_q         <= avs.avs_write;
        dropped      <= 1'b0;
        otg_hpi_addr <= avs.avs_address;
        otg_hpi_cs_n <= 1'b0;
        otg_data_oe  <= avs.avs_write;
        if (avs.avs_write) otg_data_out <= avs.avs_writedata;
      end
    end
  end

  fake_mario_otg_hpi_sync u_irq_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (otg_hpi_int),
    .q       (irq)
  );

endmodule

// File: tb/tb_fake_mario_otg_hpi_bridge.sv
// Bench for the HPI bridge: two instances (default timing and SETUP=2/STROBE=1/HOLD=3)
// driven through one Avalon master, checked against a cycle-pattern model of the HPI pins.
module tb_fake_mario_otg_hpi_bridge;
  import fake_mario_otg_hpi_pkg::*;

  localparam int B_SETUP = 2;
  localparam int B_STROBE = 1;
  localparam int B_HOLD = 3;
  localparam int B_REC = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Avalon master variables; sel routes the request to instance A (0) or B (1)
  bit          sel = 1'b0;
  logic        m_cs = 1'b0, m_rd = 1'b0, m_wr = 1'b0;
  logic [1:0]  m_addr = '0;
  logic [15:0] m_wd = '0;
  logic        hpi_int = 1'b0;
  logic [15:0] resp_val = '0;
  logic [15:0] data_in;
  logic [15:0] exp_rd [2];

  fake_mario_otg_hpi_if ifa ();
  fake_mario_otg_hpi_if ifb ();

  logic [1:0]  a_addr, b_addr, p_addr;
  logic        a_cs_n, a_r_n, a_w_n, a_oe, a_irq;
  logic        b_cs_n, b_r_n, b_w_n, b_oe, b_irq;
  logic        p_cs_n, p_r_n, p_w_n, p_oe, p_wait;
  logic [15:0] a_dout, b_dout, p_dout, p_rdata;

  always_comb begin
    ifa.avs_chipselect = m_cs & ~sel;
    ifb.avs_chipselect = m_cs & sel;
    ifa.avs_read = m_rd;       ifb.avs_read = m_rd;
    ifa.avs_write = m_wr;      ifb.avs_write = m_wr;
    ifa.avs_address = m_addr;  ifb.avs_address = m_addr;
    ifa.avs_writedata = m_wd;  ifb.avs_writedata = m_wd;
    p_addr  = sel ? b_addr : a_addr;
    p_cs_n  = sel ? b_cs_n : a_cs_n;
    p_r_n   = sel ? b_r_n : a_r_n;
    p_w_n   = sel ? b_w_n : a_w_n;
    p_oe    = sel ? b_oe : a_oe;
    p_dout  = sel ? b_dout : a_dout;
    p_wait  = sel ? ifb.avs_waitrequest : ifa.avs_waitrequest;
    p_rdata = sel ? ifb.avs_readdata : ifa.avs_readdata;
    // HPI responder: drives programmed data only while the chip is being read
    data_in = (!p_cs_n && !p_r_n) ? resp_val : 16'hDEAD;
  end

  fake_mario_otg_hpi_bridge dut_a (
    .clk(clk), .reset_n(reset_n), .avs(ifa),
    .otg_hpi_addr(a_addr), .otg_hpi_cs_n(a_cs_n), .otg_hpi_r_n(a_r_n), .otg_hpi_w_n(a_w_n),
    .otg_data_in(data_in), .otg_data_out(a_dout), .otg_data_oe(a_oe),
    .otg_hpi_int(hpi_int), .irq(a_irq)
  );

  fake_mario_otg_hpi_bridge #(
    .SETUP_CYC(B_SETUP), .STROBE_CYC(B_STROBE), .HOLD_CYC(B_HOLD), .RECOVERY_CYC(B_REC)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .avs(ifb),
    .otg_hpi_addr(b_addr), .otg_hpi_cs_n(b_cs_n), .otg_hpi_r_n(b_r_n), .otg_hpi_w_n(b_w_n),
    .otg_data_in(data_in), .otg_data_out(b_dout), .otg_data_oe(b_oe),
    .otg_hpi_int(hpi_int), .irq(b_irq)
  );

  // One Avalon access. lead = cycles the request waits in recovery before acceptance.
  // keep = leave the request up so the caller can chain a back-to-back access.
  // drop_at = cycle at which the master abandons the request (-1: never).
  task automatic access(input logic wr, input logic rd, input logic [1:0] addr,
                        input logic [15:0] wd, input logic [15:0] rv, input int lead,
                        input bit keep, input int drop_at, input string tag);
    int s, st, h, r, total, k;
    bit req_on, cs_act, stb;
    s  = sel ? B_SETUP : int'(DEF_SETUP_CYC);
    st = sel ? B_STROBE : int'(DEF_STROBE_CYC);
    h  = sel ? B_HOLD : int'(DEF_HOLD_CYC);
    r  = sel ? B_REC : int'(DEF_RECOVERY_CYC);
    total = s + st + h;
    resp_val = rv;
    @(posedge clk); #1;
    m_cs = 1'b1; m_rd = rd; m_wr = wr; m_addr = addr; m_wd = wd; req_on = 1'b1;
    for (int c = 0; c <= lead + total; c++) begin
      @(negedge clk);
      k = c - lead;
      cs_act = (k >= 1) && (k <= total);
      stb = (k >= s + 1) && (k <= s + st);
      n_cmp++;
      if (p_cs_n !== !cs_act) begin
        n_err++; $display("FAIL %s cs_n c=%0d: got %b want %b", tag, c, p_cs_n, !cs_act);
      end
      n_cmp++;
      if (p_r_n !== !(stb && !wr)) begin
        n_err++; $display("FAIL %s r_n c=%0d: got %b want %b", tag, c, p_r_n, !(stb && !wr));
      end
      n_cmp++;
      if (p_w_n !== !(stb && wr)) begin
        n_err++; $display("FAIL %s w_n c=%0d: got %b want %b", tag, c, p_w_n, !(stb && wr));
      end
      n_cmp++;
      if (p_oe !== (cs_act && wr)) begin
        n_err++; $display("FAIL %s oe c=%0d: got %b want %b", tag, c, p_oe, cs_act && wr);
      end
      if (cs_act) begin
        n_cmp++;
        if (p_addr !== addr) begin
          n_err++; $display("FAIL %s addr c=%0d: got %0d want %0d", tag, c, p_addr, addr);
        end
      end
      if (cs_act && wr) begin
        n_cmp++;
        if (p_dout !== wd) begin
          n_err++; $display("FAIL %s wdata c=%0d: got %h want %h", tag, c, p_dout, wd);
        end
      end
      n_cmp++;
      if (p_wait !== (req_on && k != total)) begin
        n_err++; $display("FAIL %s waitrequest c=%0d: got %b want %b", tag, c, p_wait, req_on && k != total);
      end
      if (k == total) begin
        if (!wr) exp_rd[sel] = rv;
        n_cmp++;
        if (p_rdata !== exp_rd[sel]) begin
          n_err++; $display("FAIL %s readdata: got %h want %h", tag, p_rdata, exp_rd[sel]);
        end
      end
      if (c == drop_at) begin
        m_cs = 1'b0; m_addr = ~addr; m_wd = ~wd; req_on = 1'b0;
      end
    end
    if (!keep) begin
      if (req_on) begin
        @(posedge clk); #1;
        m_cs = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
      end
      for (int c = 1; c <= r; c++) begin
        @(negedge clk);
        n_cmp++;
        if ({p_cs_n, p_r_n, p_w_n, p_oe, p_wait} !== 5'b11100) begin
          n_err++; $display("FAIL %s recovery c=%0d: got cs/r/w/oe/wait=%b want 11100", tag, c,
                            {p_cs_n, p_r_n, p_w_n, p_oe, p_wait});
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({a_cs_n, a_r_n, a_w_n, a_oe, a_addr, a_irq} !== 7'b1110000 || a_dout !== 16'h0
        || ifa.avs_readdata !== 16'h0 || ifa.avs_waitrequest !== 1'b0) begin
      n_err++; $display("FAIL reset_a: got cs/r/w/oe/addr/irq=%b dout=%h rd=%h", 
                        {a_cs_n, a_r_n, a_w_n, a_oe, a_addr, a_irq}, a_dout, ifa.avs_readdata);
    end
    n_cmp++;
    if ({b_cs_n, b_r_n, b_w_n, b_oe, b_addr, b_irq} !== 7'b1110000 || b_dout !== 16'h0
        || ifb.avs_readdata !== 16'h0) begin
      n_err++; $display("FAIL reset_b: got cs/r/w/oe/addr/irq=%b dout=%h rd=%h",
                        {b_cs_n, b_r_n, b_w_n, b_oe, b_addr, b_irq}, b_dout, ifb.avs_readdata);
    end
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic test_write();
    sel = 1'b0;
    access(1'b1, 1'b0, HPI_REG_ADDRESS, 16'h1234, 16'h0, 0, 1'b0, -1, "write");
  endtask

  task automatic test_read();
    sel = 1'b0;
    access(1'b0, 1'b1, HPI_REG_DATA, 16'h0, 16'hBEEF, 0, 1'b0, -1, "read");
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    access(1'b1, 1'b0, HPI_REG_MAILBOX, 16'hA5A5, 16'h0, 0, 1'b1, -1, "b2b_wr");
    access(1'b0, 1'b1, HPI_REG_STATUS, 16'h0, 16'h5AC3, int'(DEF_RECOVERY_CYC) - 1, 1'b0, -1, "b2b_rd");
  endtask

  task automatic test_write_wins();
    sel = 1'b0;
    access(1'b1, 1'b1, HPI_REG_DATA, 16'h00FF, 16'h7777, 0, 1'b0, -1, "write_wins");
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    @(posedge clk); #1;
    m_cs = 1'b1; m_wr = 1'b1; m_rd = 1'b0; m_addr = 2'd1; m_wd = 16'hC0DE;
    repeat (DEF_SETUP_CYC + 2) @(posedge clk);
    #2;
    n_cmp++;
    if ({a_cs_n, a_w_n, a_oe} !== 3'b001) begin
      n_err++; $display("FAIL reset_mid_pre: got cs/w/oe=%b want 001", {a_cs_n, a_w_n, a_oe});
    end
    reset_n = 1'b0;
    m_cs = 1'b0; m_wr = 1'b0;
    #1;
    n_cmp++;
    if ({a_cs_n, a_r_n, a_w_n, a_oe} !== 4'b1110) begin
      n_err++; $display("FAIL reset_mid_pins: got cs/r/w/oe=%b want 1110", {a_cs_n, a_r_n, a_w_n, a_oe});
    end
    exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
    n_cmp++;
    if (ifa.avs_readdata !== 16'h0) begin
      n_err++; $display("FAIL reset_mid_readdata: got %h want 0000", ifa.avs_readdata);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    access(1'b0, 1'b1, HPI_REG_MAILBOX, 16'h0, 16'h4321, 0, 1'b0, -1, "after_reset");
  endtask

  task automatic test_irq();
    int lat_a, lat_b, run_a, run_b;
    lat_a = -1; lat_b = -1; run_a = 0; run_b = 0;
    @(posedge clk); #3 hpi_int = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (a_irq) begin run_a++; if (lat_a < 0) lat_a = i; end
      if (b_irq) begin run_b++; if (lat_b < 0) lat_b = i; end
      if (i == 5) #2 hpi_int = 1'b0;
    end
    n_cmp++;
    if (lat_a < 2 || lat_a > 3) begin n_err++; $display("FAIL irq_latency_a: got %0d want 2..3", lat_a); end
    n_cmp++;
    if (run_a != 5) begin n_err++; $display("FAIL irq_width_a: got %0d want 5", run_a); end
    n_cmp++;
    if (lat_b < 2 || lat_b > 3) begin n_err++; $display("FAIL irq_latency_b: got %0d want 2..3", lat_b); end
    n_cmp++;
    if (run_b != 5) begin n_err++; $display("FAIL irq_width_b: got %0d want 5", run_b); end
  endtask

  task automatic test_alt_timing();
    sel = 1'b1;
    access(1'b1, 1'b0, HPI_REG_ADDRESS, 16'h8001, 16'h0, 0, 1'b0, -1, "alt_wr");
    access(1'b0, 1'b1, HPI_REG_DATA, 16'h0, 16'h1357, 0, 1'b1, -1, "alt_rd");
    access(1'b1, 1'b0, HPI_REG_DATA, 16'hFFFF, 16'h0, B_REC - 1, 1'b0, -1, "alt_b2b");
  endtask

  task automatic test_req_drop();
    sel = 1'b0;
    access(1'b1, 1'b0, HPI_REG_MAILBOX, 16'h3C3C, 16'h0, 0, 1'b0, int'(DEF_SETUP_CYC) + 1, "drop_a");
    sel = 1'b1;
    access(1'b1, 1'b0, HPI_REG_STATUS, 16'h0F0F, 16'h0, 0, 1'b0, 1, "drop_b");
  endtask

  task automatic test_random();
    bit keep_prev, kp;
    int mode, rec;
    keep_prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!keep_prev) sel = 1'($urandom_range(0, 1));
      rec = sel ? B_REC : int'(DEF_RECOVERY_CYC);
      mode = int'($urandom_range(0, 2));
      kp = (i != 39) && ($urandom_range(0, 2) == 0);
      access(mode != 1, mode != 0, 2'($urandom), 16'($urandom), 16'($urandom),
             keep_prev ? rec - 1 : 0, kp, -1, "random");
      keep_prev = kp;
      if (!kp) repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_write_wins();
    test_reset_mid();
    test_irq();
    test_alt_timing();
    test_req_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
